// File: rtl/zmaps_pkg.sv
// zmaps_pkg: shared constants and the CPU write-queue entry record for the
// ZMAPS FPRAM write path.
//   FILE_CODE_W - width of the a[11:9] word-file code
//   MAX_FILES   - largest number of word files the code space can address
//   ADDR_MAX_W  - widest per-file word address an entry can carry
//   REG_CODE    - a[11:8] code selecting the byte register space
//   wq_entry_t  - queued CPU word: file code, word address, 16-bit data
package zmaps_pkg;

  localparam int FILE_CODE_W = 3;
  localparam int MAX_FILES   = 7;
  localparam int ADDR_MAX_W  = 15;

  localparam logic [3:0] REG_CODE = 4'hE;

  typedef struct packed {
    logic [FILE_CODE_W-1:0] file;
    logic [ADDR_MAX_W-1:0]  addr;
    logic [15:0]            data;
  } wq_entry_t;

  localparam int ENTRY_W = $bits(wq_entry_t);

endpackage

// File: rtl/zmaps_wq.sv
// zmaps_wq: synchronous FIFO holding CPU word writes until the file write
// port is free.
//   clk, rst_n      - clock, synchronous active-low reset (pointers/count only)
//   push, din       - enqueue request and entry
//   pop, dout       - dequeue request and current head entry
//   full, empty     - occupancy flags
//   count           - number of stored entries
// A push into a full FIFO is only taken when a pop happens in the same cycle.
module zmaps_wq #(
  parameter int QDEPTH = 4,
  parameter int WIDTH  = 34
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [WIDTH-1:0]          din,
  input  logic                      pop,
  output logic [WIDTH-1:0]          dout,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(QDEPTH):0]   count
);

  localparam int PW = $clog2(QDEPTH);

  logic [WIDTH-1:0] mem [QDEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == ($clog2(QDEPTH)+1)'(QDEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/zmaps_queued.sv
// zmaps_queued: Z80 write window into NFILES word-wide FPRAM files plus a
// byte register space. CPU byte pairs (even then odd) are assembled into
// words and queued; DMA writes have absolute priority on the file port.
//   clk, rst_n                 - clock, synchronous active-low reset
//   memwr_s, a, d, fmaddr      - CPU write strobe, address, data, window select
//   dma_we, dma_addr, dma_data - one-hot DMA file write
//   wr_we, wr_addr, wr_data    - registered one-hot file write port
//   regs_we, regs_addr, regs_data - registered byte register write
//   ovf, ovf_clr, pair_err     - sticky error flags and their clear
module zmaps_queued
  import zmaps_pkg::*;
#(
  parameter int NFILES      = 4,
  parameter int AW          = 8,
  parameter int QDEPTH      = 4,
  parameter int STRICT_PAIR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memwr_s,
  input  logic [15:0]       a,
  input  logic [7:0]        d,
  input  logic [4:0]        fmaddr,
  input  logic [NFILES-1:0] dma_we,
  input  logic [AW-1:0]     dma_addr,
  input  logic [15:0]       dma_data,
  output logic [NFILES-1:0] wr_we,
  output logic [AW-1:0]     wr_addr,
  output logic [15:0]       wr_data,
  output logic              regs_we,
  output logic [7:0]        regs_addr,
  output logic [7:0]        regs_data,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic              pair_err
);

  logic                   hit;
  logic [FILE_CODE_W-1:0] fcode;
  logic [AW-1:0]          waddr;
  logic                   file_hit;
  logic                   reg_hit;
  logic                   even_wr;
  logic                   odd_wr;
  logic                   pair_ok;
  logic                   push_req;
  logic                   pair_bad;
  logic                   ovf_set;

  logic                   lo_valid;
  logic [7:0]             lo_byte;
  logic [FILE_CODE_W-1:0] lo_file;
  logic [AW-1:0]          lo_addr;

  wq_entry_t              q_in;
  wq_entry_t              q_head;
  logic                   q_pop;
  logic                   q_full;
  logic                   q_empty;
  logic [$clog2(QDEPTH):0] q_count;
  logic                   dma_idle;
  logic                   dma_valid;
  logic                   unused_bits;

  // Address decode of the CPU strobe
  assign hit      = memwr_s & fmaddr[4] & (a[15:12] == fmaddr[3:0]);
  assign fcode    = a[11:9];
  assign waddr    = a[AW:1];
  assign file_hit = hit & (32'(fcode) < NFILES);
  assign reg_hit  = hit & (a[11:8] == REG_CODE);
  assign even_wr  = file_hit & ~a[0];
  assign odd_wr   = file_hit & a[0];

  // The odd byte only completes a word if it targets the latched even byte.
  assign pair_ok  = lo_valid & (lo_file == fcode) & (lo_addr == waddr);
  assign push_req = odd_wr & ((STRICT_PAIR == 0) | pair_ok);
  assign pair_bad = odd_wr & ~push_req;

  assign q_in.file = fcode;
  assign q_in.addr = ADDR_MAX_W'(waddr);
  assign q_in.data = {d, lo_byte};

  // A multi-hot DMA request still blocks the queue but writes nothing.
  assign dma_idle  = (dma_we == '0);
  assign dma_valid = $onehot(dma_we);
  assign q_pop     = dma_idle & ~q_empty;
  assign ovf_set   = push_req & q_full & ~q_pop;

  assign unused_bits = ^{q_count, q_head.addr};

  zmaps_wq #(
    .QDEPTH (QDEPTH),
    .WIDTH  (ENTRY_W)
  ) u_wq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .din   (q_in),
    .pop   (q_pop),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // Low-byte latch for CPU byte pairing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lo_valid <= 1'b0;
      lo_byte  <= '0;
      lo_file  <= '0;
      lo_addr  <= '0;
    end else if (even_wr) begin
      lo_valid <= 1'b1;
      lo_byte  <= d;
      lo_file  <= fcode;
      lo_addr  <= waddr;
    end else if (odd_wr) begin
      lo_valid <= 1'b0;
    end
  end

  // Registered output stage: file port, register port, sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_we     <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      regs_we   <= 1'b0;
      regs_addr <= '0;
      regs_data <= '0;
      ovf       <= 1'b0;
      pair_err  <= 1'b0;
    end else begin
      if (!dma_idle) begin
        wr_we <= dma_valid ? dma_we : '0;
        if (dma_valid) begin
          wr_addr <= dma_addr;
          wr_data <= dma_data;
        end
      end else if (!q_empty) begin
        wr_we   <= NFILES'(1) << q_head.file;
        wr_addr <= q_head.addr[AW-1:0];
        wr_data <= q_head.data;
      end else begin
        wr_we <= '0;
      end

      regs_we <= reg_hit;
      if (reg_hit) begin
        regs_addr <= a[7:0];
        regs_data <= d;
      end

      // A fresh error in the clear cycle keeps the flag set.
      ovf      <= ovf_set  | (ovf & ~ovf_clr);
      pair_err <= pair_bad | (pair_err & ~ovf_clr);
    end
  end

endmodule

// File: tb/tb_zmaps_queued.sv
// tb_zmaps_queued: directed scenarios plus randomized traffic checked against
// a transaction-level reference model (queue of pending words, pairing latch).
module tb_zmaps_queued;

  localparam int NFILES      = 4;
  localparam int AW          = 8;
  localparam int QDEPTH      = 4;
  localparam int STRICT_PAIR = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              memwr_s;
  logic [15:0]       a;
  logic [7:0]        d;
  logic [4:0]        fmaddr;
  logic [NFILES-1:0] dma_we;
  logic [AW-1:0]     dma_addr;
  logic [15:0]       dma_data;
  logic [NFILES-1:0] wr_we;
  logic [AW-1:0]     wr_addr;
  logic [15:0]       wr_data;
  logic              regs_we;
  logic [7:0]        regs_addr;
  logic [7:0]        regs_data;
  logic              ovf;
  logic              ovf_clr;
  logic              pair_err;

  always #5 clk = ~clk;

  zmaps_queued #(
    .NFILES(NFILES), .AW(AW), .QDEPTH(QDEPTH), .STRICT_PAIR(STRICT_PAIR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .memwr_s(memwr_s), .a(a), .d(d), .fmaddr(fmaddr),
    .dma_we(dma_we), .dma_addr(dma_addr), .dma_data(dma_data),
    .wr_we(wr_we), .wr_addr(wr_addr), .wr_data(wr_data),
    .regs_we(regs_we), .regs_addr(regs_addr), .regs_data(regs_data),
    .ovf(ovf), .ovf_clr(ovf_clr), .pair_err(pair_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  typedef struct { int file; int addr; int data; } word_t;
  word_t mq[$];
  bit m_lo_valid;
  int m_lo_byte, m_lo_file, m_lo_addr;
  bit m_ovf, m_perr;
  int e_wr_we, e_wr_addr, e_wr_data, e_regs_we, e_regs_addr, e_regs_data;

  // One clock: predict from current inputs, advance, compare after the edge.
  task automatic step();
    int f, wa;
    bit hit, is_file, is_reg, pop, ovf_set, perr_set, in_rst;
    word_t w, h;
    in_rst = !rst_n;
    if (in_rst) begin
      mq.delete();
      m_lo_valid = 0; m_lo_byte = 0; m_ovf = 0; m_perr = 0;
      e_wr_we = 0; e_wr_addr = 0; e_wr_data = 0;
      e_regs_we = 0; e_regs_addr = 0; e_regs_data = 0;
    end else begin
      hit     = memwr_s && fmaddr[4] && (a[15:12] == fmaddr[3:0]);
      f       = a[11:9];
      wa      = (a >> 1) % (1 << AW);
      is_file = hit && (f < NFILES);
      is_reg  = hit && (a[11:8] == 4'hE);
      ovf_set = 0; perr_set = 0;
      pop     = (dma_we == 0) && (mq.size() > 0);
      e_regs_we = is_reg;
      if (is_reg) begin e_regs_addr = a[7:0]; e_regs_data = d; end
      if (dma_we != 0) begin
        if ($countones(dma_we) == 1) begin
          e_wr_we = dma_we; e_wr_addr = dma_addr; e_wr_data = dma_data;
        end else e_wr_we = 0;
      end else if (pop) begin
        h = mq.pop_front();
        e_wr_we = 1 << h.file; e_wr_addr = h.addr; e_wr_data = h.data;
      end else e_wr_we = 0;
      if (is_file && !a[0]) begin
        m_lo_valid = 1; m_lo_byte = d; m_lo_file = f; m_lo_addr = wa;
      end else if (is_file && a[0]) begin
        if (STRICT_PAIR != 0 && !(m_lo_valid && m_lo_file == f && m_lo_addr == wa))
          perr_set = 1;
        else begin
          w = '{f, wa, d * 256 + m_lo_byte};
          if (mq.size() < QDEPTH) mq.push_back(w);
          else ovf_set = 1;
        end
        m_lo_valid = 0;
      end
      m_ovf  = ovf_set  ? 1 : (ovf_clr ? 0 : m_ovf);
      m_perr = perr_set ? 1 : (ovf_clr ? 0 : m_perr);
    end
    @(posedge clk);
    #1;
    chk("wr_we", wr_we, e_wr_we);
    chk("regs_we", regs_we, e_regs_we);
    chk("ovf", ovf, m_ovf);
    chk("pair_err", pair_err, m_perr);
    if (in_rst || e_wr_we != 0) begin
      chk("wr_addr", wr_addr, e_wr_addr);
      chk("wr_data", wr_data, e_wr_data);
    end
    if (in_rst || e_regs_we != 0) begin
      chk("regs_addr", regs_addr, e_regs_addr);
      chk("regs_data", regs_data, e_regs_data);
    end
  endtask

  task automatic idle();
    rst_n = 1'b1; memwr_s = 1'b0; dma_we = '0; ovf_clr = 1'b0;
  endtask

  task automatic cpu_wr(input logic [15:0] addr, input logic [7:0] data);
    memwr_s = 1'b1; a = addr; d = data;
    step();
    memwr_s = 1'b0;
  endtask

  int dma_cnt, cpu_cnt;
  int cpu_addr[$], cpu_data[$];
  logic [15:0] last_even;

  initial begin
    rst_n = 1'b0; memwr_s = 1'b0; a = '0; d = '0; fmaddr = '0;
    dma_we = '0; dma_addr = '0; dma_data = '0; ovf_clr = 1'b0;

    // Reset state
    step(); step();
    chk("rst_wr_we", wr_we, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_ovf", ovf, 0);
    idle();
    step();

    // Basic paired word with 2-cycle latency
    fmaddr = 5'h15;
    cpu_wr(16'h5002, 8'h34);
    cpu_wr(16'h5003, 8'h12);
    chk("lat_early_we", wr_we, 0);
    step();
    chk("pair_we", wr_we, 4'b0001);
    chk("pair_addr", wr_addr, 8'h01);
    chk("pair_data", wr_data, 16'h1234);
    step();

    // Unpaired odd byte
    cpu_wr(16'h5203, 8'h77);
    chk("unpaired_perr", pair_err, 1);
    step();
    chk("unpaired_we", wr_we, 0);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("perr_clr", pair_err, 0);

    // Register space write
    cpu_wr(16'h5E07, 8'hA5);
    chk("reg_we", regs_we, 1);
    chk("reg_addr", regs_addr, 8'h07);
    chk("reg_data", regs_data, 8'hA5);
    chk("reg_no_wr", wr_we, 0);
    step();
    chk("reg_one_cycle", regs_we, 0);

    // DMA held 10 cycles while 5 CPU words arrive into a 4-deep queue
    dma_cnt = 0; cpu_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      dma_we = 4'b0100; dma_addr = 8'(8'h80 + i); dma_data = 16'(16'hD000 + i);
      memwr_s = 1'b1;
      a = 16'(16'h5010 + 2 * (i / 2) + (i % 2));
      d = (i % 2 == 0) ? 8'(8'h10 + i / 2) : 8'(8'hC0 + i / 2);
      step();
      if (wr_we == 4'b0100) dma_cnt++;
    end
    idle();
    for (int i = 0; i < 12; i++) begin
      step();
      if (wr_we == 4'b0001) begin
        cpu_cnt++; cpu_addr.push_back(wr_addr); cpu_data.push_back(wr_data);
      end
    end
    chk("dma_count", dma_cnt, 10);
    chk("cpu_count", cpu_cnt, 4);
    chk("dma_ovf", ovf, 1);
    for (int k = 0; k < cpu_data.size() && k < 4; k++) begin
      chk("cpu_order_addr", cpu_addr[k], 8 + k);
      chk("cpu_order_data", cpu_data[k], ((8'hC0 + k) << 8) | (8'h10 + k));
    end
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 0);

    // Reset between the even and odd bytes
    cpu_wr(16'h5004, 8'h11);
    rst_n = 1'b0; step();
    chk("midrst_we", wr_we, 0);
    chk("midrst_regs", regs_we, 0);
    chk("midrst_perr", pair_err, 0);
    rst_n = 1'b1;
    cpu_wr(16'h5005, 8'h22);
    chk("midrst_drop_perr", pair_err, 1);
    step();
    chk("midrst_drop_we", wr_we, 0);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;

    // Window disabled, then page mismatch
    for (int pass = 0; pass < 2; pass++) begin
      fmaddr = (pass == 0) ? 5'h05 : 5'h16;
      cpu_wr(16'h5002, 8'h01);
      cpu_wr(16'h5003, 8'h02);
      cpu_wr(16'h5E01, 8'h03);
      chk("miss_regs", regs_we, 0);
      step(); step();
      chk("miss_we", wr_we, 0);
      chk("miss_perr", pair_err, 0);
    end
    fmaddr = 5'h15;

    // Randomized traffic
    last_even = 16'h5000;
    for (int n = 0; n < 1500; n++) begin
      int r, rd;
      logic [3:0] hi;
      idle();
      hi = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h5;
      r = $urandom_range(0, 9);
      if (r >= 4) begin
        memwr_s = 1'b1; d = 8'($urandom);
        case (r)
          4, 5: begin
            a = {hi, 3'($urandom_range(0, 4)), 9'($urandom)};
            a[0] = 1'b0; last_even = a;
          end
          6, 7: a = last_even | 16'h0001;
          8: a = {hi, 3'($urandom_range(0, 7)), 9'($urandom)} | 16'h0001;
          default: a = {hi, 4'hE, 8'($urandom)};
        endcase
      end
      rd = $urandom_range(0, 9);
      if (rd == 7 || rd == 8) dma_we = 4'(1 << $urandom_range(0, 3));
      else if (rd == 9) dma_we = 4'($urandom);
      dma_addr = 8'($urandom); dma_data = 16'($urandom);
      ovf_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      if ($urandom_range(0, 99) == 0) fmaddr = 5'($urandom);
      else if ($urandom_range(0, 9) == 0) fmaddr = 5'h15;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
